// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sched_pkg
//  Description : Shared types and constants for the lockstep ALU scheduler.
//                Holds the controller state encoding, the datapath widths
//                of the alu_xor_4 macro and the lane-compare helper.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_sched_pkg;

    localparam int SEL_W  = 2;    // ALU op-select width
    localparam int DATA_W = 4;    // ALU operand / result width

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        RESP  = 3'd4
    } state_t;

    // The two lanes disagree if any result bit differs or the carries differ.
    function automatic logic lane_mismatch(input logic [DATA_W-1:0] x,
                                           input logic              y);
        return (x != '0) || y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : NREQ-wide round-robin arbiter (NREQ = 2..4). Offers a
//                one-hot grant to the first requester at or after the
//                pointer; the pointer moves past the winner only when the
//                grant is accepted.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                i_req             request vector
//                i_accept          consumer takes the offered grant
//                o_grant           one-hot grant offer
//                o_grant_idx       binary index of the offered grant
//                o_grant_valid     some requester is offered
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_accept,
    output logic [NREQ-1:0] o_grant,
    output logic [1:0]      o_grant_idx,
    output logic            o_grant_valid
);

    logic [1:0] r_ptr_q;
    logic [1:0] w_ptr_d;
    logic [2:0] w_dist;
    logic [2:0] w_best_dist;

    // Each active requester is ranked by its distance from the pointer
    // (modulo NREQ); the smallest distance wins.
    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_dist        = '0;
        w_best_dist   = '0;
        w_ptr_d       = r_ptr_q;

        for (int i = 0; i < NREQ; i++) begin
            w_dist = 3'(i) + 3'(NREQ) - {1'b0, r_ptr_q};
            if (w_dist >= 3'(NREQ)) begin
                w_dist = w_dist - 3'(NREQ);
            end
            if (i_req[i] && (!o_grant_valid || (w_dist < w_best_dist))) begin
                o_grant_valid = 1'b1;
                w_best_dist   = w_dist;
                o_grant_idx   = 2'(i);
            end
        end

        for (int i = 0; i < NREQ; i++) begin
            o_grant[i] = o_grant_valid && (o_grant_idx == 2'(i));
        end

        if (i_accept && o_grant_valid) begin
            w_ptr_d = (o_grant_idx == 2'(NREQ - 1)) ? 2'd0 : o_grant_idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_lockstep_sched.sv
`default_nettype none
// ============================================================================
//  Module      : alu_lockstep_sched
//  Description : Controller/arbiter for the dual-lane lockstep alu_xor_4
//                macro. Grants requesters round-robin, drives identical
//                operands into both lanes, checks the lane-compare outputs
//                after ALU_LAT cycles, retries on mismatch and returns the
//                result with a fault flag. Keeps a saturating mismatch
//                counter and a sticky fault flag.
//  Ports       : wb_clk_i, wb_rst_i        clock, sync active-high reset
//                req_valid_i/req_ready_o   request handshake (ready = grant)
//                req_a_i/req_b_i/req_sel_i packed per-requester operands
//                rsp_*                     response channel
//                alu_*_o / alu_*_i         lane operands and lane results
//                clr_err_i                 clears err_count_o/fault_sticky_o
//                err_count_o, fault_sticky_o  error status
//  Revision    : 1.0  initial release
// ============================================================================
module alu_lockstep_sched #(
    parameter int NREQ      = 2,
    parameter int ALU_LAT   = 1,
    parameter int MAX_RETRY = 2,
    parameter int ERR_W     = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [4*NREQ-1:0] req_a_i,
    input  logic [4*NREQ-1:0] req_b_i,
    input  logic [2*NREQ-1:0] req_sel_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [1:0]        rsp_id_o,
    output logic [3:0]        rsp_result_o,
    output logic              rsp_carry_o,
    output logic              rsp_fault_o,
    output logic [3:0]        alu_a0_o,
    output logic [3:0]        alu_b0_o,
    output logic [3:0]        alu_a1_o,
    output logic [3:0]        alu_b1_o,
    output logic [1:0]        alu_sel1_o,
    output logic [1:0]        alu_sel2_o,
    input  logic [3:0]        alu_out1_i,
    input  logic              alu_carry1_i,
    input  logic [3:0]        alu_x_i,
    input  logic              alu_y_i,
    input  logic              clr_err_i,
    output logic [ERR_W-1:0]  err_count_o,
    output logic              fault_sticky_o
);

    import alu_sched_pkg::*;

    localparam int                 RETRY_W     = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0] C_MAX_RETRY = RETRY_W'(MAX_RETRY);
    localparam int                 WAIT_W      = 2;
    localparam logic [WAIT_W-1:0]  C_WAIT_LOAD = WAIT_W'(ALU_LAT - 1);

    state_t              r_state_q,  w_state_d;
    logic [1:0]          r_id_q,     w_id_d;
    logic [DATA_W-1:0]   r_a_q,      w_a_d;
    logic [DATA_W-1:0]   r_b_q,      w_b_d;
    logic [SEL_W-1:0]    r_sel_q,    w_sel_d;
    logic [DATA_W-1:0]   r_result_q, w_result_d;
    logic                r_carry_q,  w_carry_d;
    logic                r_fault_q,  w_fault_d;
    logic [RETRY_W-1:0]  r_retry_q,  w_retry_d;
    logic [WAIT_W-1:0]   r_wait_q,   w_wait_d;
    logic [ERR_W-1:0]    r_err_q,    w_err_d;
    logic                r_sticky_q, w_sticky_d;

    logic [NREQ-1:0]     w_arb_grant;
    logic [1:0]          w_arb_idx;
    logic                w_arb_valid;
    logic                w_accept;
    logic [DATA_W-1:0]   w_req_a;
    logic [DATA_W-1:0]   w_req_b;
    logic [SEL_W-1:0]    w_req_sel;
    logic                w_mismatch;
    logic                w_drive;

    // ------------------------------------------------------------------
    // Arbitration: a grant is only offered while idle and out of reset.
    // ------------------------------------------------------------------
    assign w_accept = (r_state_q == IDLE) && !wb_rst_i && w_arb_valid;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk           (wb_clk_i),
        .rst           (wb_rst_i),
        .i_req         (req_valid_i),
        .i_accept      (w_accept),
        .o_grant       (w_arb_grant),
        .o_grant_idx   (w_arb_idx),
        .o_grant_valid (w_arb_valid)
    );

    assign req_ready_o = w_accept ? w_arb_grant : '0;

    // Select the granted requester's operands.
    always_comb begin
        w_req_a   = '0;
        w_req_b   = '0;
        w_req_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_grant[i]) begin
                w_req_a   = req_a_i[i*DATA_W +: DATA_W];
                w_req_b   = req_b_i[i*DATA_W +: DATA_W];
                w_req_sel = req_sel_i[i*SEL_W +: SEL_W];
            end
        end
    end

    assign w_mismatch = lane_mismatch(alu_x_i, alu_y_i);

    // ------------------------------------------------------------------
    // Controller next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_id_d     = r_id_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_sel_d    = r_sel_q;
        w_result_d = r_result_q;
        w_carry_d  = r_carry_q;
        w_fault_d  = r_fault_q;
        w_retry_d  = r_retry_q;
        w_wait_d   = r_wait_q;
        w_err_d    = r_err_q;
        w_sticky_d = r_sticky_q;

        case (r_state_q)
            IDLE: begin
                if (w_accept) begin
                    w_id_d    = w_arb_idx;
                    w_a_d     = w_req_a;
                    w_b_d     = w_req_b;
                    w_sel_d   = w_req_sel;
                    w_retry_d = '0;
                    w_state_d = ISSUE;
                end
            end

            ISSUE: begin
                // ISSUE is itself the first operand-stable cycle, so a
                // single-cycle ALU needs no WAIT cycles at all.
                w_wait_d  = C_WAIT_LOAD;
                w_state_d = (C_WAIT_LOAD == '0) ? CHECK : WAIT;
            end

            WAIT: begin
                w_wait_d = r_wait_q - WAIT_W'(1);
                if (r_wait_q <= WAIT_W'(1)) begin
                    w_state_d = CHECK;
                end
            end

            CHECK: begin
                if (w_mismatch && (r_err_q != '1)) begin
                    w_err_d = r_err_q + ERR_W'(1);
                end
                if (w_mismatch && (r_retry_q < C_MAX_RETRY)) begin
                    w_retry_d = r_retry_q + RETRY_W'(1);
                    w_state_d = ISSUE;
                end else begin
                    w_result_d = alu_out1_i;
                    w_carry_d  = alu_carry1_i;
                    w_fault_d  = w_mismatch;
                    if (w_mismatch) begin
                        w_sticky_d = 1'b1;
                    end
                    w_state_d = RESP;
                end
            end

            RESP: begin
                if (rsp_ready_i) begin
                    w_state_d = IDLE;
                end
            end

            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Clearing wins over a same-cycle increment or fault report.
        if (clr_err_i) begin
            w_err_d    = '0;
            w_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state_q  <= IDLE;
            r_id_q     <= '0;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_sel_q    <= '0;
            r_result_q <= '0;
            r_carry_q  <= 1'b0;
            r_fault_q  <= 1'b0;
            r_retry_q  <= '0;
            r_wait_q   <= '0;
            r_err_q    <= '0;
            r_sticky_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_id_q     <= w_id_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_sel_q    <= w_sel_d;
            r_result_q <= w_result_d;
            r_carry_q  <= w_carry_d;
            r_fault_q  <= w_fault_d;
            r_retry_q  <= w_retry_d;
            r_wait_q   <= w_wait_d;
            r_err_q    <= w_err_d;
            r_sticky_q <= w_sticky_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Lane operands stay driven through CHECK so that the lanes
    // still see the same inputs at the sampling point.
    // ------------------------------------------------------------------
    assign w_drive = (r_state_q == ISSUE) || (r_state_q == WAIT) ||
                     (r_state_q == CHECK);

    assign alu_a0_o   = w_drive ? r_a_q   : '0;
    assign alu_a1_o   = w_drive ? r_a_q   : '0;
    assign alu_b0_o   = w_drive ? r_b_q   : '0;
    assign alu_b1_o   = w_drive ? r_b_q   : '0;
    assign alu_sel1_o = w_drive ? r_sel_q : '0;
    assign alu_sel2_o = w_drive ? r_sel_q : '0;

    assign rsp_valid_o    = (r_state_q == RESP);
    assign rsp_id_o       = r_id_q;
    assign rsp_result_o   = r_result_q;
    assign rsp_carry_o    = r_carry_q;
    assign rsp_fault_o    = r_fault_q;
    assign err_count_o    = r_err_q;
    assign fault_sticky_o = r_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_lockstep_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_lockstep_sched
//  Description : Directed bench for alu_lockstep_sched. Two instances share
//                the request side: one with ALU_LAT=1, one with ALU_LAT=3.
//                Each has its own lane model (00 add, 01 xor, 10 and, 11 or)
//                with injectable result/carry disagreement.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_lockstep_sched;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] req_sel;
    logic       rsp_ready;
    logic       clr_err;
    logic [3:0] inj_x;
    logic       inj_y;
    logic       use3;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    // Per-instance outputs: suffix 1 -> ALU_LAT=1, suffix 3 -> ALU_LAT=3.
    logic [1:0] ready1, ready3, id1, id3, s1_1, s2_1, s1_3, s2_3;
    logic       rv1, rv3, c1, c3, f1, f3, st1, st3;
    logic [3:0] res1, res3, a0_1, b0_1, a1_1, b1_1, a0_3, b0_3, a1_3, b1_3;
    logic [7:0] err1, err3;
    logic [4:0] l0_1, l1_1, l0_3, l1_3;
    logic [3:0] x1, x3;
    logic       y1, y3;

    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] s);
        case (s)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a ^ b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign l1_1 = alu_f(a1_1, b1_1, s1_1);
    assign l0_1 = alu_f(a0_1, b0_1, s2_1);
    assign x1   = l0_1[3:0] ^ l1_1[3:0] ^ inj_x;
    assign y1   = (l0_1[4] ^ l1_1[4]) | inj_y;
    assign l1_3 = alu_f(a1_3, b1_3, s1_3);
    assign l0_3 = alu_f(a0_3, b0_3, s2_3);
    assign x3   = l0_3[3:0] ^ l1_3[3:0] ^ inj_x;
    assign y3   = (l0_3[4] ^ l1_3[4]) | inj_y;

    alu_lockstep_sched #(.NREQ(2), .ALU_LAT(1), .MAX_RETRY(2), .ERR_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready1),
        .req_a_i(req_a), .req_b_i(req_b), .req_sel_i(req_sel),
        .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready), .rsp_id_o(id1),
        .rsp_result_o(res1), .rsp_carry_o(c1), .rsp_fault_o(f1),
        .alu_a0_o(a0_1), .alu_b0_o(b0_1), .alu_a1_o(a1_1), .alu_b1_o(b1_1),
        .alu_sel1_o(s1_1), .alu_sel2_o(s2_1), .alu_out1_i(l1_1[3:0]),
        .alu_carry1_i(l1_1[4]), .alu_x_i(x1), .alu_y_i(y1), .clr_err_i(clr_err),
        .err_count_o(err1), .fault_sticky_o(st1)
    );

    alu_lockstep_sched #(.NREQ(2), .ALU_LAT(3), .MAX_RETRY(2), .ERR_W(8)) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready3),
        .req_a_i(req_a), .req_b_i(req_b), .req_sel_i(req_sel),
        .rsp_valid_o(rv3), .rsp_ready_i(rsp_ready), .rsp_id_o(id3),
        .rsp_result_o(res3), .rsp_carry_o(c3), .rsp_fault_o(f3),
        .alu_a0_o(a0_3), .alu_b0_o(b0_3), .alu_a1_o(a1_3), .alu_b1_o(b1_3),
        .alu_sel1_o(s1_3), .alu_sel2_o(s2_3), .alu_out1_i(l1_3[3:0]),
        .alu_carry1_i(l1_3[4]), .alu_x_i(x3), .alu_y_i(y3), .clr_err_i(clr_err),
        .err_count_o(err3), .fault_sticky_o(st3)
    );

    // View of whichever instance is under test.
    wire [1:0]  m_ready = use3 ? ready3 : ready1;
    wire        m_rv    = use3 ? rv3 : rv1;
    wire [7:0]  m_rsp   = use3 ? {id3, res3, c3, f3} : {id1, res1, c1, f1};
    wire [7:0]  m_err   = use3 ? err3 : err1;
    wire        m_st    = use3 ? st3 : st1;
    wire [19:0] m_alu   = use3 ? {a0_3, b0_3, a1_3, b1_3, s1_3, s2_3}
                               : {a0_1, b0_1, a1_1, b1_1, s1_1, s2_1};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0;
        inj_x = '0; inj_y = 1'b0; rsp_ready = 1'b1; clr_err = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] s);
        req_a[id*4 +: 4]   = a;
        req_b[id*4 +: 4]   = b;
        req_sel[id*2 +: 2] = s;
        req_valid[id]      = 1'b1;
    endtask

    task automatic wait_grant(output int gc, output logic [1:0] g);
        bit done = 1'b0;
        g  = '0;
        gc = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (m_ready != 2'b00) begin
                g = m_ready; gc = cyc; done = 1'b1;
            end
        end
        if (!done) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int rc);
        bit done = 1'b0;
        rc = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (m_rv) begin
                rc = cyc; done = 1'b1;
            end
        end
        if (!done) chk("rsp_timeout", 0, 1);
    endtask

    initial begin
        int         gc, rc, prev;
        logic [1:0] g;
        logic       seen;

        use3 = 1'b0;

        // ---- single request ------------------------------------------
        do_reset();
        @(negedge clk);
        chk("reset_outs", {m_ready, m_rv, m_rsp, m_err, m_st}, 0);
        chk("reset_alu", m_alu, 0);
        step();
        set_req(0, 4'h3, 4'h5, 2'b00);
        wait_grant(gc, g);
        chk("t1_grant", g, 2'b01);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_issue_ops", m_alu, {4'h3, 4'h5, 4'h3, 4'h5, 2'b00, 2'b00});
        wait_rsp(rc);
        chk("t1_latency", rc - gc, 3);
        chk("t1_rsp", m_rsp, {2'd0, 4'h8, 1'b0, 1'b0});
        chk("t1_alu_idle", m_alu, 0);
        chk("t1_err", {m_err, m_st}, 0);

        // ---- contention ----------------------------------------------
        do_reset();
        set_req(0, 4'h3, 4'h5, 2'b01);
        set_req(1, 4'hF, 4'h1, 2'b00);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(gc, g);
            chk("t2_grant", g, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) chk("t2_gap", gc - prev, 4);
            prev = gc;
        end
        step();
        req_valid = '0;
        wait_rsp(rc);
        chk("t2_rsp", m_rsp, {2'd1, 4'h0, 1'b1, 1'b0});

        // ---- transient fault -----------------------------------------
        do_reset();
        set_req(1, 4'h7, 4'h2, 2'b10);
        wait_grant(gc, g);
        chk("t3_grant", g, 2'b10);
        inj_x = 4'h1;
        step();
        req_valid = '0;
        step();
        step();
        inj_x = 4'h0;
        wait_rsp(rc);
        chk("t3_latency", rc - gc, 5);
        chk("t3_rsp", m_rsp, {2'd1, 4'h2, 1'b0, 1'b0});
        chk("t3_err", {m_err, m_st}, {8'd1, 1'b0});

        // ---- persistent fault, then clear ----------------------------
        do_reset();
        inj_y = 1'b1;
        set_req(0, 4'hC, 4'h3, 2'b11);
        wait_grant(gc, g);
        step();
        req_valid = '0;
        wait_rsp(rc);
        chk("t4_latency", rc - gc, 7);
        chk("t4_rsp", m_rsp, {2'd0, 4'hF, 1'b0, 1'b1});
        chk("t4_err", {m_err, m_st}, {8'd3, 1'b1});
        step();
        inj_y   = 1'b0;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        @(negedge clk);
        chk("t4_cleared", {m_err, m_st}, 0);

        // ---- backpressure with a mid-transaction request -------------
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 4'h9, 4'h9, 2'b00);
        wait_grant(gc, g);
        chk("t5_grant0", g, 2'b01);
        step();
        req_valid[0] = 1'b0;
        set_req(1, 4'h1, 4'h2, 2'b01);
        wait_rsp(rc);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("t5_hold", {m_ready, m_rv, m_rsp}, {2'b00, 1'b1, 2'd0, 4'h2, 1'b1, 1'b0});
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5_handshake", {m_ready, m_rv, m_rsp}, {2'b00, 1'b1, 2'd0, 4'h2, 1'b1, 1'b0});
        step();
        @(negedge clk);
        chk("t5_next_grant", {m_ready, m_rv}, {2'b10, 1'b0});
        step();
        req_valid = '0;
        wait_rsp(rc);
        chk("t5_rsp1", m_rsp, {2'd1, 4'h3, 1'b0, 1'b0});

        // ---- ALU_LAT=3: latency, then reset in WAIT ------------------
        use3 = 1'b1;
        do_reset();
        set_req(0, 4'h6, 4'h7, 2'b00);
        wait_grant(gc, g);
        chk("t6_grant", g, 2'b01);
        step();
        req_valid = '0;
        wait_rsp(rc);
        chk("t6_latency", rc - gc, 5);
        chk("t6_rsp", m_rsp, {2'd0, 4'hD, 1'b0, 1'b0});
        step();
        set_req(0, 4'h1, 4'h1, 2'b00);
        wait_grant(gc, g);
        step();
        req_valid = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_outs", {m_ready, m_rv, m_rsp, m_err, m_st}, 0);
        chk("t6_rst_alu", m_alu, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | m_rv;
        end
        chk("t6_no_rsp", seen, 0);
        step();
        set_req(0, 4'h2, 4'h4, 2'b00);
        set_req(1, 4'h5, 4'h5, 2'b00);
        wait_grant(gc, g);
        chk("t6_ptr_zero", g, 2'b01);
        step();
        req_valid = '0;
        wait_rsp(rc);
        chk("t6_rsp2", m_rsp, {2'd0, 4'h6, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
